// File: rtl/edge_detect_multi.sv
// Multi-channel edge detector: per-channel synchroniser, mode-selected edge pulses,
// saturating event counters with sticky overflow flags.
module edge_detect_multi #(
  parameter int unsigned CH          = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CH-1:0]         din,
  input  logic [1:0]            mode,
  input  logic                  clr,
  output logic [CH-1:0]         pulse,
  output logic                  any_edge,
  output logic [CH*CNT_W-1:0]   cnt,
  output logic [CH-1:0]         ovf
);

  localparam int unsigned     PrimeCycles = SYNC_STAGES + 1;
  localparam int unsigned     PrimeW      = $clog2(PrimeCycles + 1);
  localparam logic [PrimeW-1:0] PrimeDone = PrimeW'(PrimeCycles);
  localparam logic [CNT_W-1:0]  CntMax    = '1;

  logic [SYNC_STAGES-1:0][CH-1:0] sync_q;
  logic [CH-1:0]                  prev_q;
  logic [CH-1:0]                  s;
  logic [CH-1:0]                  rise;
  logic [CH-1:0]                  fall;
  logic [CH-1:0]                  edge_sel;
  logic [CH-1:0]                  edge_hit;
  logic [PrimeW-1:0]              prime_q;
  logic                           primed;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= s;
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Hold off detection until the chain and prev hold post-reset samples of din.
  always_ff @(posedge clk) begin
    if (rst) begin
      prime_q <= '0;
    end else if (!primed) begin
      prime_q <= prime_q + PrimeW'(1);
    end
  end

  assign primed = (prime_q == PrimeDone);
  assign rise   = s & ~prev_q;
  assign fall   = ~s & prev_q;

  always_comb begin
    edge_sel = '0;
    unique case (mode)
      2'b00:   edge_sel = '0;
      2'b01:   edge_sel = rise;
      2'b10:   edge_sel = fall;
      2'b11:   edge_sel = rise | fall;
      default: edge_sel = '0;
    endcase
  end

  assign edge_hit = primed ? edge_sel : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      pulse    <= '0;
      any_edge <= 1'b0;
    end else begin
      pulse    <= edge_hit;
      any_edge <= |edge_hit;
    end
  end

  for (genvar i = 0; i < CH; i++) begin : gen_ch
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             ovf_q;
    logic             ovf_d;

    // clr outranks a coincident event; the pulse itself is unaffected.
    always_comb begin
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (clr) begin
        cnt_d = '0;
        ovf_d = 1'b0;
      end else if (edge_hit[i]) begin
        if (cnt_q == CntMax) begin
          ovf_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        ovf_q <= ovf_d;
      end
    end

    assign cnt[i*CNT_W +: CNT_W] = cnt_q;
    assign ovf[i]                = ovf_q;
  end

endmodule

// File: tb/tb_edge_detect_multi.sv
// Directed self-checking bench for edge_detect_multi (CH=4, SYNC_STAGES=2, CNT_W=8).
module tb_edge_detect_multi;

  logic        clk;
  logic        rst;
  logic [3:0]  din;
  logic [1:0]  mode;
  logic        clr;
  logic [3:0]  pulse;
  logic        any_edge;
  logic [31:0] cnt;
  logic [3:0]  ovf;

  int vectors;
  int miscompares;

  edge_detect_multi #(
    .CH          (4),
    .SYNC_STAGES (2),
    .CNT_W       (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .mode     (mode),
    .clr      (clr),
    .pulse    (pulse),
    .any_edge (any_edge),
    .cnt      (cnt),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] lvl);
    rst  = 1'b1;
    clr  = 1'b0;
    din  = lvl;
    repeat (3) tick();
    rst = 1'b0;
    repeat (5) tick();
  endtask

  task automatic test_reset();
    int seen;
    rst  = 1'b1;
    clr  = 1'b0;
    mode = 2'b11;
    din  = 4'b1111;
    repeat (3) tick();
    vectors++;
    if (pulse !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_pulse: got %b expected %b", pulse, 4'b0000);
    end
    vectors++;
    if (any_edge !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_any_edge: got %b expected 0", any_edge);
    end
    vectors++;
    if (cnt !== 32'h0 || ovf !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_cnt_ovf: got cnt=%h ovf=%b expected 0/0", cnt, ovf);
    end
    rst  = 1'b0;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (pulse !== 4'b0000 || any_edge !== 1'b0) seen++;
    end
    vectors++;
    if (seen != 0 || cnt !== 32'h0 || ovf !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_release_quiet: got %0d pulse cycles cnt=%h ovf=%b expected 0/0/0",
               seen, cnt, ovf);
    end
  endtask

  task automatic test_rise_only();
    int seen;
    do_reset(4'b0000);
    mode   = 2'b01;
    din[0] = 1'b1;
    tick();  // E0
    tick();  // E1
    vectors++;
    if (pulse !== 4'b0000) begin
      miscompares++;
      $display("FAIL rise_early: got %b expected 0000", pulse);
    end
    tick();  // E2
    vectors++;
    if (pulse !== 4'b0001 || any_edge !== 1'b1) begin
      miscompares++;
      $display("FAIL rise_pulse: got %b/%b expected 0001/1", pulse, any_edge);
    end
    vectors++;
    if (cnt[7:0] !== 8'd1) begin
      miscompares++;
      $display("FAIL rise_cnt: got %0d expected 1", cnt[7:0]);
    end
    tick();
    vectors++;
    if (pulse !== 4'b0000) begin
      miscompares++;
      $display("FAIL rise_one_cycle: got %b expected 0000", pulse);
    end
    din[0] = 1'b0;
    seen   = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (pulse !== 4'b0000) seen++;
    end
    vectors++;
    if (seen != 0 || cnt[7:0] !== 8'd1) begin
      miscompares++;
      $display("FAIL rise_ignores_fall: got %0d pulses cnt=%0d expected 0/1", seen, cnt[7:0]);
    end
  endtask

  task automatic test_mode_select();
    int seen;
    do_reset(4'b0000);
    mode   = 2'b00;
    din[2] = 1'b1;
    seen   = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (pulse !== 4'b0000) seen++;
    end
    vectors++;
    if (seen != 0 || cnt !== 32'h0) begin
      miscompares++;
      $display("FAIL mode_none: got %0d pulses cnt=%h expected 0/0", seen, cnt);
    end
    mode   = 2'b10;
    din[2] = 1'b0;
    tick();
    tick();
    tick();
    vectors++;
    if (pulse !== 4'b0100 || cnt[23:16] !== 8'd1) begin
      miscompares++;
      $display("FAIL mode_fall: got %b cnt=%0d expected 0100/1", pulse, cnt[23:16]);
    end
  endtask

  task automatic test_toggle_both();
    int good;
    int bad;
    int mirror_bad;
    do_reset(4'b0000);
    mode       = 2'b11;
    good       = 0;
    bad        = 0;
    mirror_bad = 0;
    for (int t = 0; t < 10; t++) begin
      din[2] = ~din[2];
      for (int k = 0; k < 4; k++) begin
        tick();
        if (pulse === 4'b0100) good++;
        else if (pulse !== 4'b0000) bad++;
        if (any_edge !== (|pulse)) mirror_bad++;
      end
    end
    vectors++;
    if (good != 10 || bad != 0) begin
      miscompares++;
      $display("FAIL toggle_pulses: got %0d good %0d bad expected 10/0", good, bad);
    end
    vectors++;
    if (mirror_bad != 0) begin
      miscompares++;
      $display("FAIL toggle_any_edge: got %0d mismatched cycles expected 0", mirror_bad);
    end
    vectors++;
    if (cnt !== 32'h000A_0000) begin
      miscompares++;
      $display("FAIL toggle_cnt: got %h expected 000a0000", cnt);
    end
  endtask

  task automatic test_saturate();
    do_reset(4'b0000);
    mode = 2'b01;
    for (int e = 0; e < 257; e++) begin
      din[1] = 1'b1;
      tick();
      tick();
      din[1] = 1'b0;
      tick();
      tick();
      if (e == 254) begin
        vectors++;
        if (cnt[15:8] !== 8'd255 || ovf !== 4'b0000) begin
          miscompares++;
          $display("FAIL sat_at_max: got cnt=%0d ovf=%b expected 255/0000", cnt[15:8], ovf);
        end
      end
    end
    repeat (3) tick();
    vectors++;
    if (cnt[15:8] !== 8'd255 || ovf !== 4'b0010) begin
      miscompares++;
      $display("FAIL sat_ovf: got cnt=%0d ovf=%b expected 255/0010", cnt[15:8], ovf);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    vectors++;
    if (cnt !== 32'h0 || ovf !== 4'b0000) begin
      miscompares++;
      $display("FAIL sat_clr: got cnt=%h ovf=%b expected 0/0000", cnt, ovf);
    end
  endtask

  task automatic test_clr_collide();
    do_reset(4'b0000);
    mode   = 2'b01;
    din[3] = 1'b1;
    repeat (4) tick();
    din[3] = 1'b0;
    repeat (4) tick();
    vectors++;
    if (cnt[31:24] !== 8'd1) begin
      miscompares++;
      $display("FAIL clr_precount: got %0d expected 1", cnt[31:24]);
    end
    din[3] = 1'b1;
    tick();  // E0
    tick();  // E1
    clr = 1'b1;
    tick();  // E2: pulse registers with clr
    clr = 1'b0;
    vectors++;
    if (pulse !== 4'b1000 || cnt[31:24] !== 8'd0) begin
      miscompares++;
      $display("FAIL clr_wins: got pulse=%b cnt=%0d expected 1000/0", pulse, cnt[31:24]);
    end
    din = 4'b0000;
    repeat (4) tick();
    din = 4'b1001;
    tick();
    tick();
    tick();
    vectors++;
    if (pulse !== 4'b1001 || any_edge !== 1'b1) begin
      miscompares++;
      $display("FAIL simul_pulse: got %b/%b expected 1001/1", pulse, any_edge);
    end
    vectors++;
    if (cnt !== 32'h0100_0001) begin
      miscompares++;
      $display("FAIL simul_cnt: got %h expected 01000001", cnt);
    end
  endtask

  task automatic test_rst_inflight();
    int seen;
    do_reset(4'b0000);
    mode   = 2'b11;
    din[1] = 1'b1;
    tick();  // E0: edge enters chain
    rst = 1'b1;
    tick();
    vectors++;
    if (pulse !== 4'b0000) begin
      miscompares++;
      $display("FAIL rst_inflight_now: got %b expected 0000", pulse);
    end
    rst  = 1'b0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (pulse !== 4'b0000) seen++;
    end
    vectors++;
    if (seen != 0 || cnt !== 32'h0 || ovf !== 4'b0000) begin
      miscompares++;
      $display("FAIL rst_inflight_after: got %0d pulses cnt=%h ovf=%b expected 0/0/0",
               seen, cnt, ovf);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst  = 1'b1;
    clr  = 1'b0;
    din  = 4'b0000;
    mode = 2'b00;
    test_reset();
    test_rise_only();
    test_mode_select();
    test_toggle_both();
    test_saturate();
    test_clr_collide();
    test_rst_inflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
